// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Package  : i2c_pkg
// Brief    : Shared widths, bit-phase encoding and FSM state types for the
//            I2C loopback subsystem (master in i2c_design, slave in
//            i2c_slave_mem).
// Revision : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 128;

    // One SCL bit is split into four equal quarter-phases
    typedef logic [1:0] phase_t;
    localparam phase_t c_PH0 = 2'd0;  // SCL low, SDA may change
    localparam phase_t c_PH1 = 2'd1;  // SCL released high
    localparam phase_t c_PH2 = 2'd2;  // SCL high, receiver samples at its end
    localparam phase_t c_PH3 = 2'd3;  // SCL driven low

    typedef enum logic [2:0] {
        M_IDLE  = 3'd0,
        M_START = 3'd1,
        M_ADDR  = 3'd2,
        M_AACK  = 3'd3,
        M_DATA  = 3'd4,
        M_DACK  = 3'd5,
        M_STOP  = 3'd6,
        M_DONE  = 3'd7
    } mst_state_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,   // waiting for START
        S_ADDR  = 3'd1,   // shifting the address byte
        S_AACK  = 3'd2,   // pull SDA low at next SCL fall
        S_AHOLD = 3'd3,   // hold address ACK until its SCL fall
        S_WDATA = 3'd4,   // shifting write data
        S_WACK  = 3'd5,   // pull SDA low at next SCL fall
        S_WHOLD = 3'd6,   // hold data ACK until its SCL fall
        S_RDATA = 3'd7    // driving read data
    } slv_state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_mem
// Brief    : Single-device I2C slave backed by a 128x8 register memory.
//            Acknowledges every address, stores written bytes and returns
//            stored bytes on reads. SDA output is open-drain style
//            (0 = pull low, 1 = release).
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_mem (
    input  logic clk,
    input  logic rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda
);
    import i2c_pkg::*;

    logic                r_scl_q;
    logic                r_sda_q;
    slv_state_t          r_state;
    logic [2:0]          r_bitcnt;
    logic [DATA_W-1:0]   r_shift;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_rw;
    logic [DATA_W-1:0]   r_mem [MEM_DEPTH];

    logic                w_rise;
    logic                w_fall;
    logic                w_start;
    logic                w_stop;
    logic                w_mem_we;
    logic [DATA_W-1:0]   w_byte_in;
    logic [DATA_W-1:0]   w_rd_byte;

    assign w_rise    = i_scl & ~r_scl_q;
    assign w_fall    = ~i_scl & r_scl_q;
    assign w_start   = i_scl & r_scl_q & r_sda_q & ~i_sda;
    assign w_stop    = i_scl & r_scl_q & ~r_sda_q & i_sda;
    assign w_byte_in = {r_shift[DATA_W-2:0], i_sda};
    assign w_rd_byte = r_mem[r_addr];
    // The 8th data bit is committed straight from the bus, no extra cycle
    assign w_mem_we  = (r_state == S_WDATA) && w_rise && (r_bitcnt == 3'd7);

    // Slave protocol FSM: bus edge detection, byte shifting, ACK and read drive
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_q  <= 1'b1;
            r_sda_q  <= 1'b1;
            r_state  <= S_IDLE;
            r_bitcnt <= 3'd0;
            r_shift  <= '0;
            r_addr   <= '0;
            r_rw     <= 1'b0;
            o_sda    <= 1'b1;
        end else begin
            r_scl_q <= i_scl;
            r_sda_q <= i_sda;
            if (w_start) begin
                // START anywhere, including repeated START mid-byte
                r_state  <= S_ADDR;
                r_bitcnt <= 3'd0;
                o_sda    <= 1'b1;
            end else if (w_stop) begin
                r_state <= S_IDLE;
                o_sda   <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        o_sda <= 1'b1;
                    end
                    S_ADDR: begin
                        if (w_rise) begin
                            r_shift  <= w_byte_in;
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                r_addr  <= r_shift[ADDR_W-1:0];
                                r_rw    <= i_sda;
                                r_state <= S_AACK;
                            end
                        end
                    end
                    S_AACK: begin
                        if (w_fall) begin
                            o_sda   <= 1'b0;
                            r_state <= S_AHOLD;
                        end
                    end
                    S_AHOLD: begin
                        if (w_fall) begin
                            r_bitcnt <= 3'd0;
                            if (r_rw) begin
                                o_sda   <= w_rd_byte[DATA_W-1];
                                r_shift <= {w_rd_byte[DATA_W-2:0], 1'b0};
                                r_state <= S_RDATA;
                            end else begin
                                o_sda   <= 1'b1;
                                r_state <= S_WDATA;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (w_rise) begin
                            r_shift  <= w_byte_in;
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                r_state <= S_WACK;
                            end
                        end
                    end
                    S_WACK: begin
                        if (w_fall) begin
                            o_sda   <= 1'b0;
                            r_state <= S_WHOLD;
                        end
                    end
                    S_WHOLD: begin
                        if (w_fall) begin
                            o_sda   <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                    S_RDATA: begin
                        if (w_fall) begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                // Last bit done: leave the ACK slot to the master
                                o_sda   <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                o_sda   <= r_shift[DATA_W-1];
                                r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Register memory, cleared on reset, written when a data byte completes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i[ADDR_W-1:0]] <= '0;
            end
        end else if (w_mem_we) begin
            r_mem[r_addr] <= w_byte_in;
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_design.sv
`default_nettype none
// ============================================================================
// Module   : i2c_design
// Brief    : I2C loopback subsystem. Single-byte master, clock divider and
//            wired-AND SCL/SDA bus; the slave side lives in i2c_slave_mem.
// Options  : I2C_DBG_PORTS_EN - adds scl_o, sda_o, busy and ack_err outputs.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_design #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       newd,
    input  logic       wr,
    input  logic [7:0] wdata,
    input  logic [6:0] addr,
    output logic [7:0] rdata,
    output logic       done
`ifdef I2C_DBG_PORTS_EN
    ,
    output logic       scl_o,
    output logic       sda_o,
    output logic       busy,
    output logic       ack_err
`endif
);
    import i2c_pkg::*;

    mst_state_t          r_state;
    phase_t              r_phase;
    logic [7:0]          r_cnt;
    logic [2:0]          r_bit;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rx;
    logic                r_rw;
    logic                r_scl;
    logic                r_sda;
    logic                r_newd_q;

    logic                w_tick;
    logic                w_newd_rise;
    logic                w_scl;
    logic                w_sda;
    logic                w_sda_s;

    assign w_tick      = (r_cnt == 8'(DIV - 1));
    assign w_newd_rise = newd & ~r_newd_q;

    // Open-drain bus: any agent pulling low wins, otherwise pulled up
    assign w_scl = r_scl;
    assign w_sda = r_sda & w_sda_s;

    i2c_slave_mem u_slave (
        .clk   (clk),
        .rst   (rst),
        .i_scl (w_scl),
        .i_sda (w_sda),
        .o_sda (w_sda_s)
    );

    // Master FSM: quarter-phase divider, SCL/SDA generation and read capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= M_IDLE;
            r_phase  <= c_PH0;
            r_cnt    <= 8'd0;
            r_bit    <= 3'd0;
            r_shift  <= '0;
            r_wdata  <= '0;
            r_rx     <= '0;
            r_rw     <= 1'b0;
            r_scl    <= 1'b1;
            r_sda    <= 1'b1;
            r_newd_q <= 1'b0;
            rdata    <= '0;
            done     <= 1'b0;
        end else begin
            r_newd_q <= newd;
            done     <= 1'b0;
            case (r_state)
                M_IDLE: begin
                    if (w_newd_rise) begin
                        r_state <= M_START;
                        r_cnt   <= 8'd0;
                        r_phase <= c_PH0;
                        r_bit   <= 3'd0;
                        r_shift <= {addr, ~wr};
                        r_wdata <= wdata;
                        r_rw    <= ~wr;
                        r_scl   <= 1'b1;
                        r_sda   <= 1'b1;
                    end
                end
                M_DONE: begin
                    done    <= 1'b1;
                    if (r_rw) begin
                        rdata <= r_rx;
                    end
                    r_state <= M_IDLE;
                end
                default: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt + 8'd1;
                    end else begin
                        r_cnt   <= 8'd0;
                        r_phase <= r_phase + 2'd1;
                        case (r_phase)
                            c_PH0: begin
                                r_scl <= 1'b1;
                            end
                            c_PH1: begin
                                // START/STOP are the only SDA moves with SCL high
                                if (r_state == M_START) begin
                                    r_sda <= 1'b0;
                                end else if (r_state == M_STOP) begin
                                    r_sda <= 1'b1;
                                end
                            end
                            c_PH2: begin
                                if (r_state != M_STOP) begin
                                    r_scl <= 1'b0;
                                end
                                if (r_state == M_DATA && r_rw) begin
                                    r_rx <= {r_rx[DATA_W-2:0], w_sda};
                                end
                            end
                            default: begin
                                // End of bit: move on and present the next SDA value
                                case (r_state)
                                    M_START: begin
                                        r_state <= M_ADDR;
                                        r_bit   <= 3'd0;
                                        r_sda   <= r_shift[DATA_W-1];
                                        r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                                    end
                                    M_ADDR: begin
                                        if (r_bit == 3'd7) begin
                                            r_state <= M_AACK;
                                            r_sda   <= 1'b1;
                                        end else begin
                                            r_bit   <= r_bit + 3'd1;
                                            r_sda   <= r_shift[DATA_W-1];
                                            r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                                        end
                                    end
                                    M_AACK: begin
                                        r_state <= M_DATA;
                                        r_bit   <= 3'd0;
                                        if (r_rw) begin
                                            r_sda <= 1'b1;
                                        end else begin
                                            r_sda   <= r_wdata[DATA_W-1];
                                            r_shift <= {r_wdata[DATA_W-2:0], 1'b0};
                                        end
                                    end
                                    M_DATA: begin
                                        if (r_bit == 3'd7) begin
                                            // Write: release for slave ACK; read: NACK
                                            r_state <= M_DACK;
                                            r_sda   <= 1'b1;
                                        end else begin
                                            r_bit <= r_bit + 3'd1;
                                            if (r_rw) begin
                                                r_sda <= 1'b1;
                                            end else begin
                                                r_sda   <= r_shift[DATA_W-1];
                                                r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                                            end
                                        end
                                    end
                                    M_DACK: begin
                                        r_state <= M_STOP;
                                        r_sda   <= 1'b0;
                                    end
                                    M_STOP: begin
                                        r_state <= M_DONE;
                                    end
                                    default: begin
                                        r_state <= M_IDLE;
                                    end
                                endcase
                            end
                        endcase
                    end
                end
            endcase
        end
    end

`ifdef I2C_DBG_PORTS_EN
    logic r_nack;

    assign scl_o = w_scl;
    assign sda_o = w_sda;
    assign busy  = (r_state != M_IDLE);

    // ACK monitor; on reads the data ACK slot belongs to the master's NACK
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nack  <= 1'b0;
            ack_err <= 1'b0;
        end else if (r_state == M_IDLE && w_newd_rise) begin
            r_nack  <= 1'b0;
            ack_err <= 1'b0;
        end else if (w_tick && r_phase == c_PH2 &&
                     (r_state == M_AACK || (r_state == M_DACK && !r_rw))) begin
            r_nack <= r_nack | w_sda;
        end else if (r_state == M_DONE) begin
            ack_err <= r_nack;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_design.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_design
// Brief    : Self-checking bench for i2c_design: directed and random
//            write/read transactions against a byte-array memory model, plus
//            a bus monitor that decodes the transferred bits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_design;

    logic       clk = 1'b0;
    logic       rst;
    logic       newd;
    logic       wr;
    logic [7:0] wdata;
    logic [6:0] addr;
    logic [7:0] rdata;
    logic       done;
`ifdef I2C_DBG_PORTS_EN
    logic       scl_o;
    logic       sda_o;
    logic       busy;
    logic       ack_err;
`endif

    i2c_design #(.DIV(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .newd  (newd),
        .wr    (wr),
        .wdata (wdata),
        .addr  (addr),
        .rdata (rdata),
        .done  (done)
`ifdef I2C_DBG_PORTS_EN
        ,
        .scl_o (scl_o),
        .sda_o (sda_o),
        .busy  (busy),
        .ack_err (ack_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain byte array plus the last value read
    logic [7:0] model_mem [128];
    logic [7:0] model_rd;

    // Bus monitor state
    logic        p_scl = 1'b1;
    logic        p_sda = 1'b1;
    int          mon_starts = 0;
    int          mon_stops  = 0;
    int          mon_nbits  = 0;
    logic [31:0] mon_bits   = '0;

    // Decode bus: SDA change with SCL high is START (fall) or STOP (rise);
    // every SCL rising edge captures one bit.
    always @(negedge clk) begin
        if (!rst) begin
            if (dut.w_scl && p_scl && (dut.w_sda !== p_sda)) begin
                if (!dut.w_sda) begin
                    mon_starts <= mon_starts + 1;
                    mon_nbits  <= 0;
                    mon_bits   <= '0;
                end else begin
                    mon_stops <= mon_stops + 1;
                end
            end else if (dut.w_scl && !p_scl) begin
                mon_bits  <= {mon_bits[30:0], dut.w_sda};
                mon_nbits <= mon_nbits + 1;
            end
        end
        p_scl <= dut.w_scl;
        p_sda <= dut.w_sda;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // mode 0: pulse newd; 1: hold newd high afterwards; 2: toggle newd while busy
    task automatic run_txn(input logic w, input logic [6:0] a, input logic [7:0] d, input int mode);
        int         cyc;
        int         s0;
        int         p0;
        logic [7:0] exp_data;
        s0    = mon_starts;
        p0    = mon_stops;
        wr    = w;
        addr  = a;
        wdata = d;
        newd  = 1'b1;
        cyc   = 0;
        while (done !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 3) begin
                // Inputs must have been latched at start
                wr    = ~w;
                addr  = ~a;
                wdata = ~d;
            end
            if (mode == 0 && cyc == 2) newd = 1'b0;
            if (mode == 2) begin
                if (cyc == 2 || cyc == 41 || cyc == 100) newd = 1'b0;
                if (cyc == 40 || cyc == 80) newd = 1'b1;
            end
        end
        if (w) begin
            model_mem[a] = d;
            exp_data     = d;
        end else begin
            model_rd = model_mem[a];
            exp_data = model_rd;
        end
        chk("done_seen", done, 1'b1);
        chk("latency_320_323", (cyc >= 320 && cyc <= 323), 1'b1);
        chk("rdata", rdata, model_rd);
        chk("start_count", mon_starts - s0, 1);
        chk("stop_count", mon_stops - p0, 1);
        chk("scl_rises", mon_nbits, 19);
        chk("addr_byte", mon_bits[18:11], {a, ~w});
        chk("addr_ack", mon_bits[10], 1'b0);
        chk("data_byte", mon_bits[9:2], exp_data);
        chk("data_ack", mon_bits[1], w ? 1'b0 : 1'b1);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        int         extra;
        int         s;
        logic       rw_r;
        logic [6:0] ra;
        logic [7:0] rd;
        logic [6:0] pool [4];
        pool = '{7'h05, 7'h41, 7'h6E, 7'h7F};

        for (int i = 0; i < 128; i++) model_mem[i] = 8'h00;
        model_rd = 8'h00;

        rst = 1'b1; newd = 1'b0; wr = 1'b0; wdata = 8'h00; addr = 7'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_done", done, 1'b0);
            chk("idle_scl", dut.w_scl, 1'b1);
        end
        chk("reset_rdata", rdata, 8'h00);

        // Basic write / read-back
        run_txn(1'b1, 7'h10, 8'h27, 0);
        run_txn(1'b0, 7'h10, 8'h00, 0);

        // Address boundaries and unwritten location
        run_txn(1'b1, 7'h00, 8'h5A, 0);
        run_txn(1'b1, 7'h7F, 8'hA5, 0);
        run_txn(1'b0, 7'h00, 8'h00, 0);
        run_txn(1'b0, 7'h7F, 8'h00, 0);
        run_txn(1'b0, 7'h33, 8'h00, 0);

        // newd held high past done must not retrigger
        run_txn(1'b1, 7'h44, 8'h3C, 1);
        extra = 0;
        s = mon_starts;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        chk("hold_extra_done", extra, 0);
        chk("hold_extra_start", mon_starts - s, 0);
        newd = 1'b0;
        @(negedge clk);

        // newd toggling while busy must not start anything extra
        run_txn(1'b0, 7'h44, 8'h00, 2);
        extra = 0;
        s = mon_starts;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        chk("toggle_extra_done", extra, 0);
        chk("toggle_extra_start", mon_starts - s, 0);

        // Random traffic over a small address pool
        for (int i = 0; i < 12; i++) begin
            rw_r = 1'($urandom_range(0, 1));
            ra   = pool[$urandom_range(0, 3)];
            rd   = 8'($urandom_range(0, 255));
            run_txn(rw_r, ra, rd, 0);
        end
        run_txn(1'b0, 7'h7F, 8'h00, 0);

        // Reset in the middle of a write's data phase
        wr = 1'b1; addr = 7'h20; wdata = 8'hC3; newd = 1'b1;
        repeat (2) @(negedge clk);
        newd = 1'b0;
        repeat (198) @(negedge clk);
        chk("in_data_phase", (mon_nbits >= 10 && mon_nbits <= 17), 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_done", done, 1'b0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_scl", dut.w_scl, 1'b1);
        chk("rst_sda", dut.w_sda, 1'b1);
        for (int i = 0; i < 128; i++) model_mem[i] = 8'h00;
        model_rd = 8'h00;
        rst = 1'b0;
        @(negedge clk);
        run_txn(1'b0, 7'h20, 8'h00, 0);
        run_txn(1'b0, 7'h10, 8'h00, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
